// File: rtl/edge_side_mean_pipe.sv
// -----------------------------------------------------------------------------
// edge_side_mean_pipe
//
// Purpose: computes the two side intensities around an edge from one 7x7 window
// per beat. A is the mean of three pixels on the far side of the edge and B is
// the mean of three pixels on the near side. The block also outputs |A-B| and
// carries the gradient-direction code of each beat along with its data. This
// stage sits between the gradient/direction classifier and the subpixel
// position solver.
//
// Pipeline: three stages (S1 select + pair sums, S2 first halving + third
// pixel, S3 second halving + contrast). All stages advance together whenever
// the output register is empty or is being drained.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   window/dir beat valid
//   in_ready   out  beat accepted this cycle (~out_valid | out_ready)
//   win        in   7x7 window, row-major; pRC at [((R-1)*7+(C-1))*PIX_W +: PIX_W]
//   dir        in   one-hot direction: 0001=(135,180) 0010=(0,45)
//                   0100=(90,135) 1000=(45,90)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   A          out  far-side mean, zero-extended to OUT_W
//   B          out  near-side mean, zero-extended to OUT_W
//   CONTRAST   out  |A-B|, zero-extended to OUT_W
//   dir_out    out  direction mapping actually used for this result
//   dir_err    out  input dir was not one-hot; the 0010 mapping was used
//
// Build option: define ESM_ROUND_EN to make both halvings round half-up.
// Without it both halvings truncate, matching the legacy A/B stage bit for bit.
// -----------------------------------------------------------------------------
module edge_side_mean_pipe #(
  parameter int PIX_W = 8,
  parameter int OUT_W = PIX_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [49*PIX_W-1:0]  win,
  input  logic [3:0]           dir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     A,
  output logic [OUT_W-1:0]     B,
  output logic [OUT_W-1:0]     CONTRAST,
  output logic [3:0]           dir_out,
  output logic                 dir_err
);

  // Sum of two pixels needs one extra bit.
  localparam int SW = PIX_W + 1;
  // Mapping used for illegal codes; also the value dir_out shows after reset.
  localparam logic [3:0] DIR_DEFAULT = 4'b0010;

  // Pixel pRC of the window, R and C counted from 1.
  function automatic logic [PIX_W-1:0] pix(input logic [49*PIX_W-1:0] w,
                                           input int r, input int c);
    return w[((r-1)*7 + (c-1))*PIX_W +: PIX_W];
  endfunction

  // ---------------------------------------------------------------------------
  // Global advance: all stages move together or all hold.
  // ---------------------------------------------------------------------------
  logic w_adv;

  // ---------------------------------------------------------------------------
  // S1 input side: pixel selection by direction
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] w_b1, w_b2, w_b3;
  logic [PIX_W-1:0] w_a1, w_a2, w_a3;
  logic [3:0]       w_dir_eff;
  logic             w_dir_err;
  logic [SW-1:0]    w_sb, w_sa;

  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    // Start from the 0010 mapping; it doubles as the fallback for bad codes.
    w_b1      = pix(win, 1, 4);
    w_b2      = pix(win, 2, 3);
    w_b3      = pix(win, 1, 3);
    w_a1      = pix(win, 6, 5);
    w_a2      = pix(win, 7, 4);
    w_a3      = pix(win, 7, 5);
    w_dir_eff = DIR_DEFAULT;
    w_dir_err = 1'b0;
    case (dir)
      4'b0001: begin
        w_b1 = pix(win, 1, 4); w_b2 = pix(win, 2, 5); w_b3 = pix(win, 1, 5);
        w_a1 = pix(win, 6, 3); w_a2 = pix(win, 7, 4); w_a3 = pix(win, 7, 3);
        w_dir_eff = dir;
      end
      4'b0010: begin
        w_dir_eff = dir;
      end
      4'b0100: begin
        w_b1 = pix(win, 4, 1); w_b2 = pix(win, 3, 2); w_b3 = pix(win, 3, 1);
        w_a1 = pix(win, 5, 6); w_a2 = pix(win, 4, 7); w_a3 = pix(win, 5, 7);
        w_dir_eff = dir;
      end
      4'b1000: begin
        w_b1 = pix(win, 3, 6); w_b2 = pix(win, 4, 7); w_b3 = pix(win, 3, 7);
        w_a1 = pix(win, 5, 2); w_a2 = pix(win, 4, 1); w_a3 = pix(win, 5, 1);
        w_dir_eff = dir;
      end
      default: begin
        // Zero or several bits set: keep the 0010 mapping and flag it.
        w_dir_err = 1'b1;
      end
    endcase
  end

  assign w_sb = {1'b0, w_b1} + {1'b0, w_b2};
  assign w_sa = {1'b0, w_a1} + {1'b0, w_a2};

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             r1_v, r2_v, r3_v;
  logic [SW-1:0]    r1_sb, r1_sa;
  logic [PIX_W-1:0] r1_b3, r1_a3;
  logic [3:0]       r1_dir, r2_dir, r3_dir;
  logic             r1_err, r2_err, r3_err;
  logic [SW-1:0]    r2_tb, r2_ta;
  logic [PIX_W-1:0] r3_b, r3_a, r3_con;

  // ---------------------------------------------------------------------------
  // S2: first halving of the pair sum, then add the third pixel.
  // (sum>>1) + p3 is at most 2*(2^PIX_W-1), so SW bits never overflow.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] w_sb_half, w_sa_half, w_tb, w_ta;

`ifdef ESM_ROUND_EN
  // Round half-up: add one before the shift, one bit wider so the +1 cannot wrap.
  assign w_sb_half = SW'(({1'b0, r1_sb} + (SW+1)'(1)) >> 1);
  assign w_sa_half = SW'(({1'b0, r1_sa} + (SW+1)'(1)) >> 1);
`else
  assign w_sb_half = r1_sb >> 1;
  assign w_sa_half = r1_sa >> 1;
`endif

  assign w_tb = w_sb_half + {1'b0, r1_b3};
  assign w_ta = w_sa_half + {1'b0, r1_a3};

  // ---------------------------------------------------------------------------
  // S3: second halving gives the mean; it always fits back into PIX_W bits.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] w_b_mean, w_a_mean, w_con;

`ifdef ESM_ROUND_EN
  assign w_b_mean = PIX_W'(({1'b0, r2_tb} + (SW+1)'(1)) >> 1);
  assign w_a_mean = PIX_W'(({1'b0, r2_ta} + (SW+1)'(1)) >> 1);
`else
  assign w_b_mean = PIX_W'(r2_tb >> 1);
  assign w_a_mean = PIX_W'(r2_ta >> 1);
`endif

  assign w_con = (w_a_mean >= w_b_mean) ? (w_a_mean - w_b_mean)
                                        : (w_b_mean - w_a_mean);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_adv    = ~r3_v | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignment so each stage reads
    // the previous stage's value from before this edge, not the new one.
    if (rst) begin
      // NOTE: data registers are cleared too, not just the valids, so the
      // outputs show defined values (A=B=CONTRAST=0) straight after reset.
      r1_v   <= 1'b0;
      r2_v   <= 1'b0;
      r3_v   <= 1'b0;
      r1_sb  <= '0;
      r1_sa  <= '0;
      r1_b3  <= '0;
      r1_a3  <= '0;
      r1_dir <= '0;
      r1_err <= 1'b0;
      r2_tb  <= '0;
      r2_ta  <= '0;
      r2_dir <= '0;
      r2_err <= 1'b0;
      r3_b   <= '0;
      r3_a   <= '0;
      r3_con <= '0;
      r3_dir <= DIR_DEFAULT;
      r3_err <= 1'b0;
    end else if (w_adv) begin
      // S1
      r1_v   <= in_valid;
      r1_sb  <= w_sb;
      r1_sa  <= w_sa;
      r1_b3  <= w_b3;
      r1_a3  <= w_a3;
      r1_dir <= w_dir_eff;
      r1_err <= w_dir_err;
      // S2
      r2_v   <= r1_v;
      r2_tb  <= w_tb;
      r2_ta  <= w_ta;
      r2_dir <= r1_dir;
      r2_err <= r1_err;
      // S3
      r3_v   <= r2_v;
      r3_b   <= w_b_mean;
      r3_a   <= w_a_mean;
      r3_con <= w_con;
      r3_dir <= r2_dir;
      r3_err <= r2_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = r3_v;
  assign A         = OUT_W'(r3_a);
  assign B         = OUT_W'(r3_b);
  assign CONTRAST  = OUT_W'(r3_con);
  assign dir_out   = r3_dir;
  assign dir_err   = r3_err;

endmodule

// File: doc/edge_side_mean_pipe.md
Name: edge_side_mean_pipe

Overview:
- Parametrised successor of the 4-direction A/B side-intensity stage in the subpixel edge pipeline.
- Takes one 7x7 window plus a one-hot gradient-direction code per accepted beat.
- Produces the two side means: A on the far side of the edge, B on the near side.
- Sits between the gradient/direction classifier and the subpixel position solver. Adds valid/ready backpressure, carries direction through the pipe, flags illegal directions, and outputs |A-B| contrast.

Parameters:
- PIX_W, 8, pixel width in bits (4..16).
- OUT_W, PIX_W+2, width of A, B and CONTRAST; results are zero-extended. OUT_W >= PIX_W is required.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  window/dir beat valid.
- in_ready  out  1  block accepts beat this cycle.
- win  in  49*PIX_W  7x7 window, row-major. Pixel pRC (R,C in 1..7) is at bits [((R-1)*7+(C-1))*PIX_W +: PIX_W].
- dir  in  4  one-hot direction: 0001 = (135,180), 0010 = (0,45), 0100 = (90,135), 1000 = (45,90).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- A  out  OUT_W  far-side mean.
- B  out  OUT_W  near-side mean.
- CONTRAST  out  OUT_W  |A-B|.
- dir_out  out  4  direction actually used for this result.
- dir_err  out  1  input dir was not one-hot; default mapping was used.

Behaviour:
- Reset (rst=1 at a clock edge): all stage valids = 0, all data registers = 0. Outputs read A=B=CONTRAST=0, dir_out=0010, dir_err=0, out_valid=0. Reset mid-operation discards all in-flight beats; in_ready=1 on the cycle after reset deasserts.
- Pipeline: three stages S1, S2, S3 with a single global advance, adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - On adv, every stage shifts. S1 valid <= in_valid.
  - When adv=0, all stages hold.
- Latency: 3 cycles, accept edge to out_valid, with out_ready held high. Throughput is 1 beat/cycle.
- dir is captured in S1 with its data and travels alongside it. The result always uses the dir of its own beat.
- Illegal dir (not exactly one bit set, including 0000): use the 0010 mapping, dir_out=0010, dir_err=1 on that result only.
- Selection in S1 (b1,b2,b3 / a1,a2,a3):
  - 0001: B from p14,p25,p15; A from p63,p74,p73.
  - 0010: B from p14,p23,p13; A from p65,p74,p75.
  - 0100: B from p41,p32,p31; A from p56,p47,p57.
  - 1000: B from p36,p47,p37; A from p52,p41,p51.
- S1 registers:
  - sb = b1+b2 and sa = a1+a2, PIX_W+1 bits, no overflow.
  - b3 and a3, PIX_W bits.
- S2: tb = (sb>>1)+b3 and ta = (sa>>1)+a3, PIX_W+1 bits.
- S3:
  - B = tb>>1 and A = ta>>1, zero-extended to OUT_W. Each is at most 2^PIX_W-1.
  - CONTRAST = (A>=B) ? A-B : B-A.
- Truncating shifts throughout unless ROUND_EN is defined.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Simultaneous in_valid and out_ready with a full pipe: one beat leaves and one enters the same cycle, with no bubble.

Optional Feature:
- Macro ESM_ROUND_EN.
- Defined: both shifts round half-up.
  - S2: tb = ((sb+1)>>1)+b3.
  - S3: B = (tb+1)>>1.
  - A uses the same form.
  - Widths are widened internally by 1 bit; results still saturate-free within PIX_W.
- Undefined: pure truncation as above, bit-exact with the legacy A/B stage for PIX_W=8.

Test Plan:
- Reset, then dir=0001 with p14=100, p25=50, p15=80, p63=10, p74=20, p73=30, out_ready=1 -> 3 cycles later out_valid=1, B=77, A=22, CONTRAST=55, dir_out=0001, dir_err=0.
- dir=1000 with p36=p47=p37=255 and p52=p41=p51=0 -> B=255, A=0, CONTRAST=255. Repeat with PIX_W=12 and all selected B pixels 4095 -> B=4095.
- dir=0110 with the 0010-mapped pixels p14=4, p23=6, p13=9 -> B=7, dir_out=0010, dir_err=1. The next legal beat has dir_err=0.
- Back-to-back 10 beats with alternating dir, out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, in order. in_ready equals ~out_valid|out_ready every cycle, and outputs are stable during stalls.
- Assert rst with 3 beats in flight -> no out_valid after reset, all outputs at reset values.
- With ESM_ROUND_EN: b1=1, b2=2, b3=0 -> B=1 (truncating build gives 0).
